// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, load/store funct3 codes and the memory-stage FSM encoding.
package cpu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/memaccess_load_align.sv
// Picks the byte/half/word lane out of a loaded word and sign- or zero-extends it.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] val_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    val_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   val_o = {24'd0, byte_sel};
      F3_H:    val_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   val_o = {16'd0, half_sel};
      default: val_o = word_i;
    endcase
  end

endmodule

// File: rtl/memaccess.sv
// Memory stage: latches the execute result, runs a single outstanding data-memory
// access for loads/stores, and presents the writeback value to decode.
module memaccess
  import cpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        E_VALID,
  input  logic [6:0]  E_OPCODE,
  input  logic [2:0]  E_FUNCT3,
  input  logic [4:0]  E_REG_D,
  input  logic [31:0] E_RESULT,
  input  logic [31:0] E_STORE_V,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_WSTRB,
  output logic [31:0] DMEM_WDATA,
  input  logic        DMEM_ACK,
  input  logic [31:0] DMEM_RDATA,
  output logic        MEM_STALL,
  output logic        M_VALID,
  output logic [4:0]  M_REG_D,
  output logic [31:0] M_REG_D_V
);

  mem_state_e  state_q, state_d;
  logic        valid_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic [31:0] result_q, storev_q, ldata_q;
  logic [31:0] ld_val;
  logic        is_load, is_store, in_wait;
  logic [3:0]  wstrb;

  assign is_load  = (opcode_q == OP_LOAD);
  assign is_store = (opcode_q == OP_STORE);
  assign in_wait  = (state_q == WAIT);

  // A capture edge always restarts the FSM; ACK only matters while waiting.
  always_comb begin
    state_d = state_q;
    if (!STALL)
      state_d = (E_VALID && is_mem_op(E_OPCODE)) ? WAIT : IDLE;
    else if (in_wait && DMEM_ACK)
      state_d = DONE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      result_q <= '0;
      storev_q <= '0;
      ldata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (!STALL) begin
        valid_q  <= E_VALID;
        opcode_q <= E_OPCODE;
        funct3_q <= E_FUNCT3;
        rd_q     <= E_REG_D;
        result_q <= E_RESULT;
        storev_q <= E_STORE_V;
      end
      if (in_wait && DMEM_ACK && is_load)
        ldata_q <= DMEM_RDATA;
    end
  end

  always_comb begin
    wstrb      = 4'b1111;
    DMEM_WDATA = storev_q;
    case (funct3_q)
      F3_B: begin
        wstrb      = 4'b0001 << result_q[1:0];
        DMEM_WDATA = {4{storev_q[7:0]}};
      end
      F3_H: begin
        wstrb      = result_q[1] ? 4'b1100 : 4'b0011;
        DMEM_WDATA = {2{storev_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign DMEM_REQ   = in_wait;
  assign MEM_STALL  = in_wait;
  assign DMEM_WE    = in_wait && is_store;
  assign DMEM_WSTRB = (in_wait && is_store) ? wstrb : 4'b0000;
  assign DMEM_ADDR  = {result_q[31:2], 2'b00};

  load_align u_align (
    .word_i   (ldata_q),
    .addr_i   (result_q[1:0]),
    .funct3_i (funct3_q),
    .val_o    (ld_val)
  );

  assign M_VALID   = valid_q && !in_wait;
  assign M_REG_D   = (is_store || opcode_q == OP_BRANCH) ? 5'd0 : rd_q;
  assign M_REG_D_V = is_load ? ld_val : result_q;

endmodule

// File: tb/tb_memaccess.sv
// Directed bench for memaccess; STALL models the external OR with MEM_STALL.
module tb_memaccess;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ext_stall;
  logic        STALL;
  logic        E_VALID;
  logic [6:0]  E_OPCODE;
  logic [2:0]  E_FUNCT3;
  logic [4:0]  E_REG_D;
  logic [31:0] E_RESULT, E_STORE_V;
  logic        DMEM_REQ, DMEM_WE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA;
  logic [3:0]  DMEM_WSTRB;
  logic        DMEM_ACK;
  logic [31:0] DMEM_RDATA;
  logic        MEM_STALL, M_VALID;
  logic [4:0]  M_REG_D;
  logic [31:0] M_REG_D_V;

  int n_assert = 0;
  int n_fail   = 0;

  assign STALL = ext_stall | MEM_STALL;

  always #5 CLK = ~CLK;

  memaccess dut (
    .CLK(CLK), .RST(RST), .STALL(STALL),
    .E_VALID(E_VALID), .E_OPCODE(E_OPCODE), .E_FUNCT3(E_FUNCT3),
    .E_REG_D(E_REG_D), .E_RESULT(E_RESULT), .E_STORE_V(E_STORE_V),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WSTRB(DMEM_WSTRB), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
    .MEM_STALL(MEM_STALL), .M_VALID(M_VALID), .M_REG_D(M_REG_D),
    .M_REG_D_V(M_REG_D_V)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sv);
    E_VALID = 1'b1; E_OPCODE = op; E_FUNCT3 = f3; E_REG_D = rd;
    E_RESULT = res; E_STORE_V = sv;
  endtask

  task automatic bubble();
    E_VALID = 1'b0; E_OPCODE = 7'd0; E_FUNCT3 = 3'd0; E_REG_D = 5'd0;
    E_RESULT = 32'd0; E_STORE_V = 32'd0;
  endtask

  initial begin
    RST = 1'b1; ext_stall = 1'b0; DMEM_ACK = 1'b0; DMEM_RDATA = 32'd0;
    bubble();
    tick(); tick();
    chk("rst_req",    {31'd0, DMEM_REQ},  32'd0);
    chk("rst_we",     {31'd0, DMEM_WE},   32'd0);
    chk("rst_wstrb",  {28'd0, DMEM_WSTRB}, 32'd0);
    chk("rst_stall",  {31'd0, MEM_STALL}, 32'd0);
    chk("rst_mvalid", {31'd0, M_VALID},   32'd0);
    chk("rst_rd",     {27'd0, M_REG_D},   32'd0);
    chk("rst_val",    M_REG_D_V,          32'd0);
    RST = 1'b0;

    // ALU op passes straight through
    issue(7'b0110011, 3'b000, 5'd5, 32'h0000_1234, 32'd0);
    tick(); bubble();
    chk("add_mvalid", {31'd0, M_VALID}, 32'd1);
    chk("add_rd",     {27'd0, M_REG_D}, 32'd5);
    chk("add_val",    M_REG_D_V,        32'h0000_1234);
    chk("add_req",    {31'd0, DMEM_REQ}, 32'd0);

    // LB 0x103, ACK after 3 wait cycles
    issue(7'b0000011, 3'b000, 5'd7, 32'h0000_0103, 32'd0);
    tick(); bubble();
    chk("lb_addr",   DMEM_ADDR,             32'h0000_0100);
    chk("lb_we",     {31'd0, DMEM_WE},      32'd0);
    chk("lb_mvalid", {31'd0, M_VALID},      32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", {31'd0, MEM_STALL}, 32'd1);
      tick();
    end
    chk("lb_stall4", {31'd0, MEM_STALL}, 32'd1);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h80FF_1122;
    tick();
    DMEM_ACK = 1'b0; DMEM_RDATA = 32'd0;
    chk("lb_stall_done", {31'd0, MEM_STALL}, 32'd0);
    chk("lb_mvalid_done", {31'd0, M_VALID},  32'd1);
    chk("lb_rd",  {27'd0, M_REG_D}, 32'd7);
    chk("lb_val", M_REG_D_V,        32'hFFFF_FF80);
    tick();
    chk("lb_idle_mvalid", {31'd0, M_VALID}, 32'd0);

    // LHU then LH at 0x202
    issue(7'b0000011, 3'b101, 5'd3, 32'h0000_0202, 32'd0);
    tick(); bubble();
    chk("lhu_req", {31'd0, DMEM_REQ}, 32'd1);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hBEEF_0000;
    tick(); DMEM_ACK = 1'b0;
    chk("lhu_val", M_REG_D_V, 32'h0000_BEEF);
    issue(7'b0000011, 3'b001, 5'd4, 32'h0000_0202, 32'd0);
    tick(); bubble();
    DMEM_ACK = 1'b1;
    tick(); DMEM_ACK = 1'b0;
    chk("lh_val", M_REG_D_V, 32'hFFFF_BEEF);

    // SB 0x301
    issue(7'b0100011, 3'b000, 5'd9, 32'h0000_0301, 32'h0000_00AB);
    tick(); bubble();
    chk("sb_we",    {31'd0, DMEM_WE},       32'd1);
    chk("sb_wstrb", {28'd0, DMEM_WSTRB},    32'b0010);
    chk("sb_wdata", DMEM_WDATA,             32'hABAB_ABAB);
    chk("sb_addr",  DMEM_ADDR,              32'h0000_0300);
    DMEM_ACK = 1'b1;
    tick(); DMEM_ACK = 1'b0;
    chk("sb_rd",     {27'd0, M_REG_D}, 32'd0);
    chk("sb_mvalid", {31'd0, M_VALID}, 32'd1);

    // SH upper half, then SW
    issue(7'b0100011, 3'b001, 5'd1, 32'h0000_0302, 32'h1234_CDEF);
    tick(); bubble();
    chk("sh_wstrb", {28'd0, DMEM_WSTRB}, 32'b1100);
    chk("sh_wdata", DMEM_WDATA,          32'hCDEF_CDEF);
    DMEM_ACK = 1'b1;
    tick(); DMEM_ACK = 1'b0;
    issue(7'b0100011, 3'b010, 5'd1, 32'h0000_0307, 32'h1234_CDEF);
    tick(); bubble();
    chk("sw_wstrb", {28'd0, DMEM_WSTRB}, 32'b1111);
    chk("sw_wdata", DMEM_WDATA,          32'h1234_CDEF);
    DMEM_ACK = 1'b1;
    tick(); DMEM_ACK = 1'b0;

    // Reset while waiting abandons the access; a late ACK is ignored
    issue(7'b0000011, 3'b010, 5'd6, 32'h0000_0400, 32'd0);
    tick(); bubble();
    chk("rstw_req", {31'd0, DMEM_REQ}, 32'd1);
    RST = 1'b1;
    tick(); RST = 1'b0;
    chk("rstw_req_after", {31'd0, DMEM_REQ}, 32'd0);
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'h5555_5555;
    tick(); DMEM_ACK = 1'b0;
    chk("rstw_req_ack",  {31'd0, DMEM_REQ},  32'd0);
    chk("rstw_mvalid",   {31'd0, M_VALID},   32'd0);
    chk("rstw_stall",    {31'd0, MEM_STALL}, 32'd0);

    // External stall held in DONE
    issue(7'b0000011, 3'b010, 5'd9, 32'h0000_0500, 32'd0);
    tick(); bubble();
    DMEM_ACK = 1'b1; DMEM_RDATA = 32'hDEAD_BEEF;
    tick(); DMEM_ACK = 1'b0; DMEM_RDATA = 32'd0;
    chk("stl_mvalid0", {31'd0, M_VALID}, 32'd1);
    chk("stl_val0",    M_REG_D_V,        32'hDEAD_BEEF);
    ext_stall = 1'b1;
    issue(7'b0000011, 3'b010, 5'd2, 32'h0000_0600, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stl_mvalid", {31'd0, M_VALID}, 32'd1);
      chk("stl_val",    M_REG_D_V,        32'hDEAD_BEEF);
      chk("stl_rd",     {27'd0, M_REG_D}, 32'd9);
      chk("stl_req",    {31'd0, DMEM_REQ}, 32'd0);
    end
    ext_stall = 1'b0; bubble();
    tick();
    chk("stl_end_req",    {31'd0, DMEM_REQ}, 32'd0);
    chk("stl_end_mvalid", {31'd0, M_VALID},  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
